// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-bounded arbiter for the async FIFO write port
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      full,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        accept,
    output logic                      w_en,
    output logic [DATA_W-1:0]         data_in,
    output logic [15:0]               word_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t             r_state, w_next_state;
    logic [NUM_REQ-1:0] r_grant, w_next_grant;
    logic [IDX_W-1:0]   r_last, w_next_last;
    logic [CNT_W-1:0]   r_cnt, w_next_cnt;
    logic [15:0]        r_word_count;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick;
    logic               w_owner_drop;
    logic               w_burst_end;
    logic [DATA_W-1:0]  w_data;
    int                 w_idx;

    // Accept is also gated by reset so nothing reaches the FIFO while reset is held low.
    assign accept     = r_grant & req & {NUM_REQ{~full}} & {NUM_REQ{reset}};
    assign w_en       = |accept;
    assign grant      = r_grant;
    assign data_in    = w_data;
    assign word_count = r_word_count;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) w_data = w_data | req_data[i*DATA_W +: DATA_W];
        end
    end

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = '0;
        w_idx        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_pick_valid && req[IDX_W'(w_idx)]) begin
                w_pick_valid = 1'b1;
                w_pick       = IDX_W'(w_idx);
            end
        end
    end

    assign w_owner_drop = |(r_grant & ~req);
    assign w_burst_end  = w_en && (r_cnt == CNT_W'(MAX_BURST - 1));

    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_last  = r_last;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = S_BURST;
                    w_next_grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                    w_next_last  = w_pick;
                    w_next_cnt   = '0;
                end
            end
            S_BURST: begin
                if (w_owner_drop || w_burst_end) begin
                    w_next_state = S_IDLE;
                    w_next_grant = '0;
                    w_next_cnt   = '0;
                end else if (w_en) begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_grant = '0;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last       <= IDX_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_word_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_last  <= w_next_last;
            r_cnt   <= w_next_cnt;
            if (w_en) r_word_count <= r_word_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  grant;
    logic [3:0]  accept;
    logic        w_en;
    logic [7:0]  data_in;
    logic [15:0] word_count;

    logic        wr_reset;
    logic [1:0]  wr_req;
    logic [15:0] wr_data;
    logic        wr_full;
    logic [1:0]  wr_grant;
    logic [1:0]  wr_accept;
    logic        wr_wen;
    logic [7:0]  wr_din;
    logic [15:0] wr_wc;

    int checks = 0;
    int errors = 0;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .full(full),
        .grant(grant), .accept(accept), .w_en(w_en), .data_in(data_in),
        .word_count(word_count)
    );

    // Long bursts let this instance reach the 16-bit wrap in about 65k cycles.
    fifo_write_arbiter #(.NUM_REQ(2), .DATA_W(8), .MAX_BURST(65536)) u_wrap (
        .clk(clk), .reset(wr_reset), .req(wr_req), .req_data(wr_data), .full(wr_full),
        .grant(wr_grant), .accept(wr_accept), .w_en(wr_wen), .data_in(wr_din),
        .word_count(wr_wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] eg;
        logic [7:0] lane;
        int n;

        reset = 1'b0; req = '0; req_data = '0; full = 1'b0;
        wr_reset = 1'b0; wr_req = '0; wr_data = 16'h2211; wr_full = 1'b0;
        tick(); tick(); #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_wen",   32'(w_en), 32'h0);
        chk("rst_wc",    32'(word_count), 32'h0);
        chk("rst_din",   32'(data_in), 32'h0);

        // 1: single requester, 4-word burst, dead cycle, regrant
        reset = 1'b1; req = 4'b0001; req_data = 32'h0000_0010;
        for (int c = 1; c <= 6; c++) begin
            tick(); #1;
            eg = (c == 5) ? 4'b0000 : 4'b0001;
            chk($sformatf("t1_grant_c%0d", c), 32'(grant), 32'(eg));
            chk($sformatf("t1_wen_c%0d", c), 32'(w_en), 32'(eg != 0));
            chk($sformatf("t1_din_c%0d", c), 32'(data_in), (eg != 0) ? 32'h10 : 32'h0);
            chk($sformatf("t1_wc_c%0d", c), 32'(word_count), (c <= 5) ? 32'(c - 1) : 32'd4);
        end
        req = 4'b0000;
        tick(); #1;
        chk("t1_drop_grant", 32'(grant), 32'h0);
        chk("t1_drop_wc",    32'(word_count), 32'd4);

        // 2: all requesting, round-robin order with one idle cycle between bursts
        reset = 1'b0;
        tick();
        reset = 1'b1; req = 4'b1111; req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int c = 0; c <= 20; c++) begin
            tick(); #1;
            eg   = ((c % 5) == 4) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
            lane = 8'hA0 + 8'h11 * 8'((c / 5) % 4);
            chk($sformatf("t2_grant_c%0d", c), 32'(grant), 32'(eg));
            chk($sformatf("t2_wen_c%0d", c), 32'(w_en), 32'(eg != 0));
            chk($sformatf("t2_din_c%0d", c), 32'(data_in), (eg != 0) ? 32'(lane) : 32'h0);
        end
        chk("t2_wc", 32'(word_count), 32'd16);
        req = 4'b0000;

        // 3: full stalls the burst mid-way without losing or repeating words
        reset = 1'b0;
        tick();
        reset = 1'b1; req = 4'b0100; req_data = 32'h00A0_0000; full = 1'b0;
        tick(); #1;
        chk("t3_g1",   32'(grant), 32'h4);
        chk("t3_din1", 32'(data_in), 32'hA0);
        chk("t3_wen1", 32'(w_en), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) begin
                req_data[23:16] = 8'hA1;
                full = 1'b1;
            end
            #1;
            chk($sformatf("t3_full_wen%0d", k), 32'(w_en), 32'h0);
            chk($sformatf("t3_full_acc%0d", k), 32'(accept), 32'h0);
            chk($sformatf("t3_full_grant%0d", k), 32'(grant), 32'h4);
        end
        tick(); full = 1'b0; #1;
        chk("t3_din2", 32'(data_in), 32'hA1);
        chk("t3_wen2", 32'(w_en), 32'h1);
        tick(); req_data[23:16] = 8'hA2; #1;
        chk("t3_din3", 32'(data_in), 32'hA2);
        chk("t3_wen3", 32'(w_en), 32'h1);
        tick(); req_data[23:16] = 8'hA3; #1;
        chk("t3_din4",   32'(data_in), 32'hA3);
        chk("t3_wen4",   32'(w_en), 32'h1);
        chk("t3_grant4", 32'(grant), 32'h4);
        tick(); #1;
        chk("t3_rel_grant", 32'(grant), 32'h0);
        chk("t3_rel_wc",    32'(word_count), 32'd4);
        req = 4'b0000;

        // 4: owner drops request early; rotation continues after requester 1
        reset = 1'b0;
        tick();
        reset = 1'b1; req = 4'b0010; req_data = {8'h04, 8'h03, 8'h02, 8'h01};
        tick(); #1;
        chk("t4_g1",   32'(grant), 32'h2);
        chk("t4_din1", 32'(data_in), 32'h02);
        tick(); #1;
        chk("t4_acc2", 32'(accept), 32'h2);
        tick(); req = 4'b0001; #1;
        chk("t4_drop_acc",   32'(accept), 32'h0);
        chk("t4_drop_grant", 32'(grant), 32'h2);
        tick(); #1;
        chk("t4_rel_grant", 32'(grant), 32'h0);
        chk("t4_rel_wc",    32'(word_count), 32'd2);
        req = 4'b0011;
        tick(); #1;
        chk("t4_rr_grant", 32'(grant), 32'h1);
        chk("t4_rr_din",   32'(data_in), 32'h01);

        // 5: reset mid-burst abandons it and restores the initial pointer
        tick(); #1;
        chk("t5_acc_cnt1", 32'(accept), 32'h1);
        tick(); reset = 1'b0; #1;
        chk("t5_wc_pre",   32'(word_count), 32'd4);
        chk("t5_rst_wen",  32'(w_en), 32'h0);
        chk("t5_rst_acc",  32'(accept), 32'h0);
        tick(); reset = 1'b1; #1;
        chk("t5_grant", 32'(grant), 32'h0);
        chk("t5_wen",   32'(w_en), 32'h0);
        chk("t5_wc",    32'(word_count), 32'h0);
        tick(); #1;
        chk("t5_first", 32'(grant), 32'h1);
        req = 4'b0000;

        // 6: word_count wraps 65534 -> 65535 -> 0 -> 1
        wr_reset = 1'b1; wr_req = 2'b01;
        n = 0;
        while (wr_wc != 16'd65534 && n < 70000) begin
            tick();
            n++;
        end
        #1;
        chk("t6_reach", 32'(wr_wc), 32'd65534);
        chk("t6_wen",   32'(wr_wen), 32'h1);
        tick(); #1;
        chk("t6_65535", 32'(wr_wc), 32'd65535);
        tick(); #1;
        chk("t6_zero",  32'(wr_wc), 32'd0);
        chk("t6_rel",   32'(wr_grant), 32'h0);
        n = 0;
        while (wr_wc == 16'd0 && n < 5) begin
            tick();
            n++;
        end
        #1;
        chk("t6_one", 32'(wr_wc), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
